fetch_pc_sequencer: RTL and testbench

- PC-generation front end of the 5-stage pipeline.
- Boots the PC from the reset vector and steps it through 1- or 2-word instructions.
- Honours stall, branch redirect and external interrupt.
- Presents instruction, immediate, PC and next PC to the IF/ID buffer, and drives the instruction-memory address.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/inst_length_decode.sv | 17 +
 rtl/fetch_pc_sequencer.sv | 123 ++++++++++++
 tb/tb_fetch_pc_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        INT_VEC
    } fetch_state_t;

    // Opcode field location in the instruction word
    localparam int unsigned OPC_HI = 15;
    localparam int unsigned OPC_LO = 11;
    localparam int unsigned OPC_W  = OPC_HI - OPC_LO + 1;

    // Opcode bits [4:3] equal to this value mark a two-word instruction
    localparam logic [1:0] OPC_IMM_CLASS = 2'b11;

    localparam int unsigned DEF_RST_VEC_ADDR = 0;
    localparam int unsigned DEF_INT_VEC_ADDR = 2;

endpackage

// File: rtl/inst_length_decode.sv
// Instruction length decode: opcode -> one or two words and the matching PC step.
module inst_length_decode
    import fetch_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output logic             is_two_word,
    output logic [1:0]       pc_inc
);

    // Only the class bits matter for length; the rest select the operation downstream
    logic [OPC_W-3:0] unused_opc_low;
    assign unused_opc_low = opcode[OPC_W-3:0];

    assign is_two_word = (opcode[OPC_W-1:OPC_W-2] == OPC_IMM_CLASS);
    assign pc_inc      = is_two_word ? 2'd2 : 2'd1;

endmodule

// File: rtl/fetch_pc_sequencer.sv
// PC-generation front end: boot vector, sequential stepping, stall, branch redirect.
// Interrupt support (pending flag, EPC, INT_VEC state) is built only when FETCH_INT_EN is defined.
module fetch_pc_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       INST_W       = 16,
    parameter logic [ADDR_W-1:0] RST_VEC_ADDR = ADDR_W'(DEF_RST_VEC_ADDR),
    parameter logic [ADDR_W-1:0] INT_VEC_ADDR = ADDR_W'(DEF_INT_VEC_ADDR)
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [INST_W-1:0] im_rdata0,
    input  logic [INST_W-1:0] im_rdata1,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              int_req,
    output logic              int_ack,
    output logic [ADDR_W-1:0] epc,
    output logic [INST_W-1:0] inst,
    output logic [INST_W-1:0] imm,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] next_pc,
    output logic              valid
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] vec_pc;
    logic              is_two_word;
    logic [1:0]        pc_inc;
    logic              take_int;

    inst_length_decode u_len (
        .opcode      (im_rdata0[OPC_HI:OPC_LO]),
        .is_two_word (is_two_word),
        .pc_inc      (pc_inc)
    );

    // Vectors are stored high word first
    assign vec_pc  = ADDR_W'({im_rdata0, im_rdata1});
    assign inst    = im_rdata0;
    assign imm     = is_two_word ? im_rdata1 : '0;
    assign pc      = pc_q;
    assign next_pc = pc_q + ADDR_W'(pc_inc);

`ifdef FETCH_INT_EN
    logic              int_pending;
    logic [ADDR_W-1:0] epc_q;

    // A redirect always wins; a stalled instruction cannot be interrupted
    assign take_int = (state == RUN) && !branch_taken && int_pending && !stall;
    assign int_ack  = !reset && (state == INT_VEC);
    assign epc      = epc_q;
`else
    logic unused_int_req;
    assign unused_int_req = int_req;
    assign take_int       = 1'b0;
    assign int_ack        = 1'b0;
    assign epc            = '0;
`endif

    assign valid = !reset && (state == RUN) && !branch_taken && !take_int;

    always_comb begin
        im_addr = pc_q;
        case (state)
            BOOT:    im_addr = RST_VEC_ADDR;
            INT_VEC: im_addr = INT_VEC_ADDR;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BOOT;
            pc_q  <= '0;
`ifdef FETCH_INT_EN
            int_pending <= 1'b0;
            epc_q       <= '0;
`endif
        end else begin
            case (state)
                BOOT: begin
                    pc_q  <= vec_pc;
                    state <= RUN;
                end
                RUN: begin
                    if (branch_taken) begin
                        pc_q <= branch_target;
`ifdef FETCH_INT_EN
                    end else if (take_int) begin
                        state <= INT_VEC;
`endif
                    end else if (!stall) begin
                        pc_q <= next_pc;
                    end
                end
`ifdef FETCH_INT_EN
                INT_VEC: begin
                    pc_q  <= vec_pc;
                    state <= RUN;
                end
`endif
                default: state <= BOOT;
            endcase
`ifdef FETCH_INT_EN
            if (take_int) begin
                epc_q <= pc_q;
            end
            // A new request in the vector cycle outranks the service clear
            if (int_req) begin
                int_pending <= 1'b1;
            end else if (state == INT_VEC) begin
                int_pending <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer; interrupt checks follow the FETCH_INT_EN build setting.
module tb_fetch_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] im_addr;
    logic [15:0] im_rdata0;
    logic [15:0] im_rdata1;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        int_req;
    logic        int_ack;
    logic [31:0] epc;
    logic [15:0] inst;
    logic [15:0] imm;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        valid;

    int n_checks = 0;
    int n_fail   = 0;

    // 256-word memory aliased over the whole address space
    logic [15:0] mem [256];
    logic [7:0]  rd_idx1;
    assign rd_idx1   = im_addr[7:0] + 8'd1;
    assign im_rdata0 = mem[im_addr[7:0]];
    assign im_rdata1 = mem[rd_idx1];

    fetch_pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .im_addr       (im_addr),
        .im_rdata0     (im_rdata0),
        .im_rdata1     (im_rdata1),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .int_req       (int_req),
        .int_ack       (int_ack),
        .epc           (epc),
        .inst          (inst),
        .imm           (imm),
        .pc            (pc),
        .next_pc       (next_pc),
        .valid         (valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h0000;
        mem[8'h01] = 16'h0010;
        mem[8'h02] = 16'h0000;
        mem[8'h03] = 16'h0080;
        mem[8'h10] = 16'h0800;
        mem[8'h11] = 16'hC000;
        mem[8'h12] = 16'h1234;
        mem[8'h13] = 16'h0800;
        mem[8'h40] = 16'h0800;
        mem[8'h80] = 16'h0800;
        mem[8'hFF] = 16'hC000;

        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0; int_req = 1'b0;

        // Two reset cycles
        tick(); settle();
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_int_ack", 32'(int_ack), 32'd0);
        tick(); settle();
        check_eq("rst_epc", epc, 32'h0);

        // BOOT
        tick(); reset = 1'b0; settle();
        check_eq("boot_valid", 32'(valid), 32'd0);
        check_eq("boot_im_addr", im_addr, 32'h0);

        // First fetch from the reset vector
        tick(); settle();
        check_eq("seq0_pc", pc, 32'h10);
        check_eq("seq0_valid", 32'(valid), 32'd1);
        check_eq("seq0_inst", 32'(inst), 32'h0800);
        check_eq("seq0_imm", 32'(imm), 32'h0);
        check_eq("seq0_next", next_pc, 32'h11);
        check_eq("seq0_im_addr", im_addr, 32'h10);

        // Two-word instruction, stalled for three cycles
        tick(); stall = 1'b1; settle();
        check_eq("seq1_pc", pc, 32'h11);
        check_eq("seq1_inst", 32'(inst), 32'hC000);
        check_eq("seq1_imm", 32'(imm), 32'h1234);
        check_eq("seq1_next", next_pc, 32'h13);
        check_eq("seq1_valid", 32'(valid), 32'd1);
        for (int k = 0; k < 2; k++) begin
            tick(); settle();
            check_eq("stall_pc", pc, 32'h11);
            check_eq("stall_inst", 32'(inst), 32'hC000);
            check_eq("stall_imm", 32'(imm), 32'h1234);
            check_eq("stall_valid", 32'(valid), 32'd1);
        end

        // Branch with stall: branch wins, current fetch killed
        tick(); branch_taken = 1'b1; branch_target = 32'h40; settle();
        check_eq("br_kill_valid", 32'(valid), 32'd0);
        check_eq("br_kill_pc", pc, 32'h11);
        tick(); branch_taken = 1'b0; stall = 1'b0; settle();
        check_eq("br_pc", pc, 32'h40);
        check_eq("br_valid", 32'(valid), 32'd1);
        check_eq("br_next", next_pc, 32'h41);

        // Branch to 0x13 with an interrupt request in the same cycle
        tick(); branch_taken = 1'b1; branch_target = 32'h13; int_req = 1'b1; settle();
        check_eq("pre_int_pc", pc, 32'h41);
        check_eq("pre_int_valid", 32'(valid), 32'd0);

`ifdef FETCH_INT_EN
        tick(); branch_taken = 1'b0; int_req = 1'b0; settle();
        check_eq("int_take_pc", pc, 32'h13);
        check_eq("int_take_valid", 32'(valid), 32'd0);
        check_eq("int_take_ack", 32'(int_ack), 32'd0);
        check_eq("int_take_epc", epc, 32'h0);

        // Vector cycle, second request arrives here
        tick(); int_req = 1'b1; settle();
        check_eq("ivec_ack", 32'(int_ack), 32'd1);
        check_eq("ivec_epc", epc, 32'h13);
        check_eq("ivec_valid", 32'(valid), 32'd0);
        check_eq("ivec_im_addr", im_addr, 32'h2);

        tick(); int_req = 1'b0; settle();
        check_eq("isr_pc", pc, 32'h80);
        check_eq("isr_ack", 32'(int_ack), 32'd0);
        check_eq("isr_repend_valid", 32'(valid), 32'd0);

        tick(); settle();
        check_eq("ivec2_ack", 32'(int_ack), 32'd1);
        check_eq("ivec2_epc", epc, 32'h80);

        tick(); int_req = 1'b1; settle();
        check_eq("isr2_pc", pc, 32'h80);
        check_eq("isr2_valid", 32'(valid), 32'd1);
        check_eq("isr2_ack", 32'(int_ack), 32'd0);

        // Pending interrupt plus branch: branch first, epc = target
        tick(); int_req = 1'b0; branch_taken = 1'b1; branch_target = 32'h50; settle();
        check_eq("brint_pc", pc, 32'h81);
        check_eq("brint_valid", 32'(valid), 32'd0);
        check_eq("brint_ack", 32'(int_ack), 32'd0);
        tick(); branch_taken = 1'b0; settle();
        check_eq("brint_tgt_pc", pc, 32'h50);
        check_eq("brint_tgt_valid", 32'(valid), 32'd0);
        tick(); settle();
        check_eq("brint_ack2", 32'(int_ack), 32'd1);
        check_eq("brint_epc", epc, 32'h50);

        // Reset during the vector cycle
        tick(); reset = 1'b1; int_req = 1'b0; settle();
        check_eq("rst_ivec_ack", 32'(int_ack), 32'd0);
        check_eq("rst_ivec_valid", 32'(valid), 32'd0);
`else
        tick(); branch_taken = 1'b0; int_req = 1'b0; settle();
        check_eq("noint_pc", pc, 32'h13);
        check_eq("noint_valid", 32'(valid), 32'd1);
        check_eq("noint_ack", 32'(int_ack), 32'd0);
        check_eq("noint_epc", epc, 32'h0);
        tick(); int_req = 1'b1; settle();
        check_eq("noint_pc2", pc, 32'h14);
        check_eq("noint_valid2", 32'(valid), 32'd1);
        tick(); int_req = 1'b0; settle();
        check_eq("noint_pc3", pc, 32'h15);
        check_eq("noint_valid3", 32'(valid), 32'd1);
        check_eq("noint_ack3", 32'(int_ack), 32'd0);
        check_eq("noint_epc3", epc, 32'h0);

        tick(); reset = 1'b1; settle();
        check_eq("rst_run_valid", 32'(valid), 32'd0);
`endif

        // Back to BOOT with nothing pending
        tick(); reset = 1'b0; settle();
        check_eq("reboot_valid", 32'(valid), 32'd0);
        check_eq("reboot_im_addr", im_addr, 32'h0);
        check_eq("reboot_ack", 32'(int_ack), 32'd0);
        check_eq("reboot_epc", epc, 32'h0);
        tick(); settle();
        check_eq("reboot_pc", pc, 32'h10);
        check_eq("reboot_run_valid", 32'(valid), 32'd1);

        // PC wrap with a two-word instruction at the top of memory
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
        tick(); branch_taken = 1'b0; settle();
        check_eq("wrap_pc", pc, 32'hFFFF_FFFF);
        check_eq("wrap_inst", 32'(inst), 32'hC000);
        check_eq("wrap_imm", 32'(imm), 32'h0);
        check_eq("wrap_next", next_pc, 32'h1);
        check_eq("wrap_valid", 32'(valid), 32'd1);
        tick(); settle();
        check_eq("wrap_pc_after", pc, 32'h1);
        check_eq("wrap_next_after", next_pc, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
